// File: rtl/mcu_serializer.sv
// Streams one captured N x N block of signed samples as saturated unsigned pixels over valid/ready.
// Define MCU_SERIALIZER_ZIGZAG_EN to emit JPEG zigzag order instead of raster order.
module mcu_serializer #(
    parameter int N     = 8,
    parameter int IN_W  = 32,
    parameter int OUT_W = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [N*N*IN_W-1:0]       in_block,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [OUT_W-1:0]          out_data,
    output logic [$clog2(N*N)-1:0]    out_index,
    output logic                      out_last
);

    localparam int NE = N * N;
    localparam int IW = $clog2(NE);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    localparam logic [IN_W-1:0] MAXV = {{(IN_W-OUT_W){1'b0}}, {OUT_W{1'b1}}};
    localparam logic [IW-1:0]   K_LAST = IW'(NE - 1);

    logic [0:0]                 state_q, state_d;
    logic [IW-1:0]              k_q, k_d;
    logic [NE-1:0][IN_W-1:0]    buf_q, buf_d;
    logic                       streaming;
    logic                       capture;
    logic [IN_W-1:0]            elem;

`ifdef MCU_SERIALIZER_ZIGZAG_EN
    // Walk the anti-diagonals, alternating direction: even diagonals go up-right, odd go down-left.
    function automatic logic [NE-1:0][IW-1:0] zz_table();
        logic [NE-1:0][IW-1:0] t;
        int k, r, lo, hi;
        t = '0;
        k = 0;
        for (int s = 0; s < 2*N-1; s++) begin
            lo = (s < N) ? 0 : s - N + 1;
            hi = (s < N) ? s : N - 1;
            for (int i = 0; i <= hi - lo; i++) begin
                r = (s % 2 == 0) ? hi - i : lo + i;
                t[k] = IW'(r * N + (s - r));
                k++;
            end
        end
        return t;
    endfunction

    localparam logic [NE-1:0][IW-1:0] ZZ = zz_table();

    assign out_index = ZZ[k_q];
`else
    assign out_index = k_q;
`endif

    assign streaming = (state_q == S_STREAM);
    assign out_valid = streaming;
    assign out_last  = streaming && (k_q == K_LAST);
    // Combinational out_ready -> in_ready lets the next block land with no bubble.
    assign in_ready  = !rst && (!streaming || (out_last && out_ready));
    assign capture   = in_valid && in_ready;

    assign elem = buf_q[out_index];

    always_comb begin
        out_data = elem[OUT_W-1:0];
        if (elem[IN_W-1]) begin
            out_data = '0;
        end else if (elem > MAXV) begin
            out_data = '1;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        buf_d   = buf_q;
        if (capture) begin
            buf_d = in_block;
        end
        case (state_q)
            S_IDLE: begin
                if (capture) begin
                    k_d     = '0;
                    state_d = S_STREAM;
                end
            end
            default: begin
                if (out_ready) begin
                    if (out_last) begin
                        k_d     = '0;
                        state_d = in_valid ? S_STREAM : S_IDLE;
                    end else begin
                        k_d = k_q + IW'(1);
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            buf_q   <= buf_d;
        end
    end

endmodule

// File: tb/tb_mcu_serializer.sv
// Directed bench for mcu_serializer (N=8, IN_W=32, OUT_W=8): raster/zigzag order, saturation,
// backpressure, back-to-back blocks and asynchronous reset mid-block.
module tb_mcu_serializer;

    localparam int N     = 8;
    localparam int IN_W  = 32;
    localparam int OUT_W = 8;
    localparam int NE    = N * N;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [NE*IN_W-1:0]   in_block = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [OUT_W-1:0]     out_data;
    logic [5:0]           out_index;
    logic                 out_last;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [NE];
    logic [NE*IN_W-1:0] blk_a, blk_b;

    // Standard JPEG 8x8 zigzag scan, written out by hand.
    int zz [NE] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
                    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
                    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

    mcu_serializer #(.N(N), .IN_W(IN_W), .OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    function automatic int order(input int k);
`ifdef MCU_SERIALIZER_ZIGZAG_EN
        return zz[k];
`else
        return k;
`endif
    endfunction

    function automatic logic [7:0] sat(input logic [31:0] x);
        if ($signed(x) < 0)   return 8'h00;
        if ($signed(x) > 255) return 8'hff;
        return x[7:0];
    endfunction

    function automatic logic [NE*IN_W-1:0] pack();
        logic [NE*IN_W-1:0] b;
        for (int e = 0; e < NE; e++) b[e*IN_W +: IN_W] = mem[e];
        return b;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Present the block in mem for one cycle; returns on the negedge after capture,
    // with in_block scrambled so a late write into the buffer would show up.
    task automatic load();
        @(negedge clk);
        in_block = pack();
        in_valid = 1'b1;
        #1;
        chk("load_rdy", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        in_block = ~pack();
    endtask

    // Check nbeats beats against mem; optional stall of stall_len cycles before beat stall_at.
    task automatic drain(input int nbeats, input int stall_at, input int stall_len, input bit end_idle);
        for (int k = 0; k < nbeats; k++) begin
            if (k == stall_at) begin
                out_ready = 1'b0;
                for (int j = 0; j < stall_len; j++) begin
                    #1;
                    chk("stall_vld",  out_valid, 1);
                    chk("stall_idx",  out_index, order(k));
                    chk("stall_data", out_data,  sat(mem[order(k)]));
                    chk("stall_last", out_last,  k == NE-1);
                    chk("stall_rdy",  in_ready,  0);
                    @(negedge clk);
                end
            end
            out_ready = 1'b1;
            #1;
            chk("beat_vld",  out_valid, 1);
            chk("beat_idx",  out_index, order(k));
            chk("beat_data", out_data,  sat(mem[order(k)]));
            chk("beat_last", out_last,  k == NE-1);
            chk("beat_rdy",  in_ready,  k == NE-1);
            @(negedge clk);
        end
        if (end_idle) begin
            #1;
            chk("idle_vld", out_valid, 0);
            chk("idle_rdy", in_ready,  1);
            chk("idle_last", out_last, 0);
        end
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_rdy",  in_ready,  0);
        chk("rst_vld",  out_valid, 0);
        chk("rst_data", out_data,  0);
        chk("rst_idx",  out_index, 0);
        chk("rst_last", out_last,  0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_rdy", in_ready,  1);
        chk("rel_vld", out_valid, 0);

        // Checkerboard: 0xff00 on even columns, 0 on odd
        for (int e = 0; e < NE; e++) mem[e] = ((e % N) % 2 == 0) ? 32'h0000_ff00 : 32'h0;
        load();
        drain(NE, -1, 0, 1'b1);

        // Saturation corners
        for (int e = 0; e < NE; e++) mem[e] = 32'(e * 4);
        mem[0] = 32'hffff_ffff;
        mem[1] = 32'd255;
        mem[2] = 32'd256;
        mem[3] = 32'd17;
        mem[4] = 32'h8000_0000;
        mem[5] = 32'h7fff_ffff;
        mem[6] = 32'h0001_0005;
        load();
        drain(NE, -1, 0, 1'b1);

        // Backpressure at beat 5 for 3 cycles
        for (int e = 0; e < NE; e++) mem[e] = 32'(e * 3);
        load();
        drain(NE, 5, 3, 1'b1);

        // Back-to-back: A (all 1) then B (all 2) with in_valid held
        for (int e = 0; e < NE; e++) mem[e] = 32'd2;
        blk_b = pack();
        for (int e = 0; e < NE; e++) mem[e] = 32'd1;
        blk_a = pack();
        @(negedge clk);
        in_block = blk_a;
        in_valid = 1'b1;
        @(negedge clk);
        in_block = blk_b;
        drain(NE, -1, 0, 1'b0);
        in_valid = 1'b0;
        in_block = '0;
        for (int e = 0; e < NE; e++) mem[e] = 32'd2;
        drain(NE, -1, 0, 1'b1);

        // Async reset between edges at beat 20
        for (int e = 0; e < NE; e++) mem[e] = 32'(e + 100);
        load();
        drain(20, -1, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_vld",  out_valid, 0);
        chk("arst_rdy",  in_ready,  0);
        chk("arst_last", out_last,  0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_rel_rdy", in_ready,  1);
        chk("arst_rel_vld", out_valid, 0);
        chk("arst_rel_idx", out_index, 0);
        load();
        drain(NE, -1, 0, 1'b1);

        // Value equals raster position, so out_data must track out_index in either build
        for (int e = 0; e < NE; e++) mem[e] = 32'(e);
        load();
        for (int k = 0; k < NE; k++) begin
            out_ready = 1'b1;
            #1;
            chk("pos_data", out_data, {26'd0, out_index});
            chk("pos_idx",  out_index, order(k));
            chk("pos_last", out_last, k == NE-1);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mcu_serializer.md
# mcu_serializer

Streams one N×N block of wide samples (an MCU) out as a sequence of saturated narrow pixels over a valid/ready handshake. It supersedes the combinational 8×8×32 flattener. It generalises block dimension and sample widths, adds input capture, backpressure, element indexing and last-beat marking, and optionally reorders the scan to JPEG zigzag. It sits between the block-level transform stage and the byte-stream packer.

## Interface
Parameters:
- N, 8, block dimension; block holds N*N elements; N ≥ 2
- IN_W, 32, input sample width, signed two's complement
- OUT_W, 8, output pixel width, unsigned; OUT_W < IN_W

Ports:
- clk  in  1  single clock; all state on rising edge
- rst  in  1  reset, asynchronous assert, active-high
- in_valid  in  1  in_block holds a complete block
- in_ready  out  1  block can be captured this cycle
- in_block  in  N*N*IN_W  packed [N][N][IN_W]; element (r,c) at bits [(r*N+c)*IN_W +: IN_W]
- out_valid  out  1  out_data/out_index/out_last valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  OUT_W  saturated pixel
- out_index  out  $clog2(N*N)  raster position r*N+c of the current element
- out_last  out  1  final beat of the block

## Operation
- States: IDLE, STREAM.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch in_block into the block buffer, clear the scan counter k=0, go to STREAM.
- STREAM:
  - out_valid=1.
  - out_index=order(k), where order is raster (k) or zigzag (see Configuration).
  - out_data=sat(buffer[out_index]).
  - out_last=(k==N*N-1).
- Beat handshake: out_valid&&out_ready advances k by 1.
- Final beat (out_last=1) handshake:
  - If in_valid: capture the new block in the same cycle, set k=0, stay in STREAM. in_ready=1 in this cycle only.
  - Otherwise: go to IDLE.
- in_ready = (state==IDLE) || (state==STREAM && out_last && out_ready). This is a combinational path from out_ready to in_ready.
- Saturation sat(x):
  - x<0 → 0.
  - x>2^OUT_W-1 → 2^OUT_W-1.
  - Otherwise → x[OUT_W-1:0].
  - Compare the full IN_W bits, never a truncated value.
- The buffer is written only on capture. in_block changes at any other time have no effect.

## Timing
- Reset values: state=IDLE, k=0, buffer cleared to 0, out_valid=0, out_last=0, out_index=0, out_data=0. in_ready=0 while rst is high, 1 in the first cycle after release.
- Reset mid-stream: out_valid drops asynchronously and the block is discarded. No partial-block resume.
- Latency: capture at edge T; first beat valid in the cycle after T.
- Throughput: N*N beats per block with no bubble between back-to-back blocks when out_ready is held high.
- Output stability: while out_valid && !out_ready, out_data, out_index and out_last hold.
- Output paths: out_data and out_index are functions of registered state only (buffer mux + saturation). out_ready affects only in_ready and the next state.
- k counts 0..N*N-1. It never wraps past N*N-1 inside a block; it resets to 0 on capture.

## Configuration
- Macro: MCU_SERIALIZER_ZIGZAG_EN.
- Defined:
  - order(k) is the JPEG zigzag scan of an N×N block, produced by an elaboration-time constant function valid for any N.
  - For N=8, out_index runs 0,1,8,16,9,2,3,10,17,24,… ending …,55,62,63.
- Undefined:
  - order(k)=k (raster scan).
  - No zigzag table logic is elaborated.
- All handshake, saturation and timing behaviour is identical in both builds.

## Test plan
- Raster checkerboard (N=8, macro off):
  - Stimulus: element (r,c)=32'hff00 for even c, 0 for odd c; out_ready held 1.
  - Response: 64 beats with out_data alternating 8'hff,8'h00; out_index 0..63; out_last only on index 63.
- Saturation:
  - Stimulus: elements 32'hffff_ffff, 32'd255, 32'd256, 32'd17.
  - Response: out_data 0, 255, 255, 17.
- Backpressure:
  - Stimulus: drop out_ready for 3 cycles at beat 5.
  - Response: out_data/out_index/out_last frozen at index 5; stream resumes at index 6 with no loss or duplication.
- Back-to-back blocks:
  - Stimulus: in_valid held high with block A (all 1) then block B (all 2).
  - Response: in_ready pulses exactly on A's last handshake; B's beat 0 follows A's beat 63 in the next cycle; 128 contiguous beats.
- Async reset mid-block:
  - Stimulus: assert rst between clock edges at beat 20.
  - Response: out_valid=0 immediately. After release, in_ready=1; the next capture starts at out_index 0.
- Zigzag (macro on, N=8):
  - Stimulus: element value = r*8+c.
  - Response: out_data equals out_index; the first six beats are 0,1,8,16,9,2; the last is 63 with out_last=1.
